// File: rtl/alu_rs.sv
// alu_rs: reservation station feeding the integer ALU.
// Captures pending operands from the CDB and issues ready ops lowest-index first.
package alu_rs_pkg;
   typedef enum logic [3:0] {
      INSN_ADD,
      INSN_SUB,
      INSN_AND,
      INSN_OR,
      INSN_XOR,
      INSN_SLL,
      INSN_SRL,
      INSN_SRA,
      INSN_SLT,
      INSN_SLTU
   } insn_t;

   typedef struct packed {
      insn_t       insn;
      logic [31:0] enc;
   } op_t;
endpackage

module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4,
   parameter int TAG_WIDTH  = 5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  op_t                        in_op,
   input  logic [DATA_WIDTH-1:0]      in_lhs,
   input  logic [DATA_WIDTH-1:0]      in_rhs,
   input  logic                       in_lhs_valid,
   input  logic                       in_rhs_valid,
   input  logic [TAG_WIDTH-1:0]       in_lhs_tag,
   input  logic [TAG_WIDTH-1:0]       in_rhs_tag,
   input  logic [TAG_WIDTH-1:0]       in_dest_tag,
   input  logic                       cdb_valid,
   input  logic [TAG_WIDTH-1:0]       cdb_tag,
   input  logic [DATA_WIDTH-1:0]      cdb_data,
   output logic                       issue_valid,
   input  logic                       issue_ready,
   output op_t                        issue_op,
   output logic [DATA_WIDTH-1:0]      issue_lhs,
   output logic [DATA_WIDTH-1:0]      issue_rhs,
   output logic [TAG_WIDTH-1:0]       issue_dest_tag,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   logic [DEPTH-1:0]      busy;
   logic [DEPTH-1:0]      lv;
   logic [DEPTH-1:0]      rv;
   op_t                   op_q   [DEPTH];
   logic [DATA_WIDTH-1:0] lhs_q  [DEPTH];
   logic [DATA_WIDTH-1:0] rhs_q  [DEPTH];
   logic [TAG_WIDTH-1:0]  lt_q   [DEPTH];
   logic [TAG_WIDTH-1:0]  rt_q   [DEPTH];
   logic [TAG_WIDTH-1:0]  dt_q   [DEPTH];

   logic                  lock_q;
   logic [IW-1:0]         lock_idx_q;

   logic [DEPTH-1:0]      rdy;
   logic [IW-1:0]         free_idx;
   logic [IW-1:0]         pick_idx;
   logic [IW-1:0]         sel_idx;
   logic                  enq;
   logic                  iss;
   logic                  in_lv;
   logic                  in_rv;
   logic [DATA_WIDTH-1:0] in_lhs_w;
   logic [DATA_WIDTH-1:0] in_rhs_w;

   assign rdy = busy & lv & rv;

   always_comb begin
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy[i]) free_idx = IW'(i);
      end
   end

   always_comb begin
      pick_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (rdy[i]) pick_idx = IW'(i);
      end
   end

   // A stalled issue keeps its slot even if a lower entry wakes up meanwhile.
   assign sel_idx     = lock_q ? lock_idx_q : pick_idx;
   assign issue_valid = |rdy;

   assign issue_op       = op_q[sel_idx];
   assign issue_lhs      = lhs_q[sel_idx];
   assign issue_rhs      = rhs_q[sel_idx];
   assign issue_dest_tag = dt_q[sel_idx];

   assign in_ready = count < CW'(DEPTH);
   assign enq      = in_valid && in_ready;
   assign iss      = issue_valid && issue_ready;

   assign in_lv    = in_lhs_valid ||
                     (cdb_valid && cdb_tag == in_lhs_tag);
   assign in_rv    = in_rhs_valid ||
                     (cdb_valid && cdb_tag == in_rhs_tag);
   assign in_lhs_w = in_lhs_valid ? in_lhs : cdb_data;
   assign in_rhs_w = in_rhs_valid ? in_rhs : cdb_data;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         busy   <= '0;
         count  <= '0;
         lock_q <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (cdb_valid && busy[i]) begin
               if (!lv[i] && lt_q[i] == cdb_tag) begin
                  lv[i]    <= 1'b1;
                  lhs_q[i] <= cdb_data;
               end
               if (!rv[i] && rt_q[i] == cdb_tag) begin
                  rv[i]    <= 1'b1;
                  rhs_q[i] <= cdb_data;
               end
            end
         end
         if (iss) busy[sel_idx] <= 1'b0;
         if (enq) begin
            busy[free_idx]  <= 1'b1;
            op_q[free_idx]  <= in_op;
            lv[free_idx]    <= in_lv;
            rv[free_idx]    <= in_rv;
            lhs_q[free_idx] <= in_lhs_w;
            rhs_q[free_idx] <= in_rhs_w;
            lt_q[free_idx]  <= in_lhs_tag;
            rt_q[free_idx]  <= in_rhs_tag;
            dt_q[free_idx]  <= in_dest_tag;
         end
         count      <= count + CW'(enq) - CW'(iss);
         lock_q     <= issue_valid && !issue_ready;
         lock_idx_q <= sel_idx;
      end
   end
endmodule
